strobe_monitor: RTL

Receive-side checker for the periodic one-clock strobe produced by the strobe generator. It measures the interval between incoming strobes and reports each measured period. It tracks lock against an expected period with a tolerance window, flags missing strobes with a timeout, and counts lock-loss errors. It sits downstream of the strobe source, for example on the debounce/encoder sample tick, as a health monitor and a bring-up observation point.

---
 rtl/strobe_monitor_if.sv | 30 +++
 rtl/strobe_monitor.sv | 112 +++++++++++
 2 files changed

// File: rtl/strobe_monitor_if.sv
// Strobe-under-test and monitor report signals; the master side drives the strobe
// and observes the reports, the slave side is the monitor itself.
interface strobe_monitor_if #(
    parameter int CW = 10
);
    logic          strobe;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;
    logic [7:0]    error_count;

    modport master (
        output strobe,
        input  period,
        input  period_valid,
        input  locked,
        input  timeout,
        input  error_count
    );

    modport slave (
        input  strobe,
        output period,
        output period_valid,
        output locked,
        output timeout,
        output error_count
    );
endinterface

// File: rtl/strobe_monitor.sv
// Measures the interval between incoming one-clock strobes, tracks lock against an
// expected period with a tolerance window, and flags missing strobes.
module strobe_monitor #(
    parameter int EXPECTED   = 129,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int CW         = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    strobe_monitor_if.slave   bus
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] WIN_LO  = CW'(EXPECTED - TOL);
    localparam logic [CW-1:0] WIN_HI  = CW'(EXPECTED + TOL);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0] LOCK_G  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] good;
    logic [GW-1:0] good_inc;
    logic [7:0]    err_inc;
    logic          in_window;
    logic          timeout_hit;

    // cnt reaches WIN_HI only once per gap, so the timeout cannot repeat within one gap
    always_comb begin
        in_window   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
        timeout_hit = (state != IDLE) && !bus.strobe && (cnt == WIN_HI);
        good_inc    = good + 1'b1;
        err_inc     = (bus.error_count == 8'hFF) ? 8'hFF : bus.error_count + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (bus.strobe) begin
            cnt <= CW'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            good             <= '0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.locked       <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.error_count  <= 8'd0;
        end else begin
            bus.period_valid <= 1'b0;
            bus.timeout      <= 1'b0;

            // IDLE has no earlier strobe to measure from
            if (bus.strobe && (state != IDLE)) begin
                bus.period       <= cnt;
                bus.period_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.strobe) begin
                        state <= HUNT;
                        good  <= '0;
                    end
                end
                HUNT: begin
                    if (bus.strobe) begin
                        if (in_window) begin
                            good <= good_inc;
                            if (good_inc == LOCK_G) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (timeout_hit) begin
                        bus.timeout <= 1'b1;
                        good        <= '0;
                    end
                end
                LOCKED: begin
                    if ((bus.strobe && !in_window) || timeout_hit) begin
                        state           <= HUNT;
                        good            <= '0;
                        bus.locked      <= 1'b0;
                        bus.error_count <= err_inc;
                        bus.timeout     <= timeout_hit;
                    end
                end
                default: begin
                    state      <= IDLE;
                    good       <= '0;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
